phy_tx_sched: RTL and testbench

PHY_TX_SCHED -- requirements
Module: phy_tx_sched

---
 rtl/phy_tx_sched.sv | 189 ++++++++++++++++++
 tb/tb_phy_tx_sched.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/phy_tx_sched.sv
// phy_tx_sched: link bring-up FSM and two-requester transmit scheduler
// sitting in front of a PHY transmitter.
//
// Brings the link up (INIT -> TRAIN -> LINK), retries training a bounded
// number of times before latching FAIL, and in LINK grants one of two
// word sources per cycle, registering the granted word towards the PHY.
//
// Ports:
//   clk_f      in   word clock (single clock domain)
//   reset      in   synchronous, active-high
//   req0/data0 in   requester 0 request and word (held stable while req0)
//   req1/data1 in   requester 1 request and word (held stable while req1)
//   rx_active  in   receiver lock indication from the RX side
//   gnt0/gnt1  out  combinational grants, LINK only, at most one per cycle
//   data_input out  registered word to the PHY transmitter
//   valid      out  registered: data_input carries a new word this cycle
//   active     out  registered: PHY transmitter enabled (TRAIN/LINK)
//   state      out  INIT=0, TRAIN=1, LINK=2, FAIL=3
//   link_fail  out  registered: training retries exhausted
//
// Build option: define PHY_SCHED_RR_EN for round-robin arbitration;
// otherwise req0 has fixed priority over req1 and no pointer is built.
module phy_tx_sched #(
  parameter int INIT_CYCLES   = 4,
  parameter int LOCK_CYCLES   = 2,
  parameter int TRAIN_TIMEOUT = 64,
  parameter int MAX_RETRIES   = 3
) (
  input  logic        clk_f,
  input  logic        reset,
  input  logic        req0,
  input  logic [31:0] data0,
  input  logic        req1,
  input  logic [31:0] data1,
  input  logic        rx_active,
  output logic        gnt0,
  output logic        gnt1,
  output logic [31:0] data_input,
  output logic        valid,
  output logic        active,
  output logic [1:0]  state,
  output logic        link_fail
);

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_TRAIN = 2'd1,
    ST_LINK  = 2'd2,
    ST_FAIL  = 2'd3
  } state_e;

  // One cycle counter serves both the INIT dwell and the TRAIN timeout.
  localparam int CYC_MAX = (INIT_CYCLES > TRAIN_TIMEOUT) ? INIT_CYCLES : TRAIN_TIMEOUT;
  localparam int CYC_W   = $clog2(CYC_MAX + 1);
  localparam int LOCK_W  = $clog2(LOCK_CYCLES + 1);
  localparam int RTY_W   = $clog2(MAX_RETRIES + 1);

  localparam logic [CYC_W-1:0]  INIT_LAST  = CYC_W'(INIT_CYCLES - 1);
  localparam logic [CYC_W-1:0]  TRAIN_LAST = CYC_W'(TRAIN_TIMEOUT - 1);
  localparam logic [CYC_W-1:0]  CYC_SAT    = CYC_W'(CYC_MAX);
  localparam logic [LOCK_W-1:0] LOCK_LAST  = LOCK_W'(LOCK_CYCLES - 1);
  localparam logic [RTY_W-1:0]  RTY_MAX    = RTY_W'(MAX_RETRIES);

  state_e            state_q, state_d;
  logic [CYC_W-1:0]  cyc_q, cyc_d;
  logic [LOCK_W-1:0] lock_q, lock_d;
  logic [RTY_W-1:0]  rty_q, rty_d;
  logic [RTY_W-1:0]  rty_inc;
  logic [31:0]       data_q, data_d;
  logic              valid_q, valid_d;
  logic              active_q, active_d;
  logic              link_fail_q, link_fail_d;
  logic              grant_ok;

  // Grants only in a healthy LINK cycle; a dropping rx_active or a reset
  // cycle suppresses them so no word is consumed and then lost.
  assign grant_ok = (state_q == ST_LINK) && rx_active && !reset;

`ifdef PHY_SCHED_RR_EN
  logic ptr_q, ptr_d;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (grant_ok) begin
      if (req0 && req1) begin
        gnt0 = !ptr_q;
        gnt1 = ptr_q;
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
    end
    // Pointer hands priority to the requester that was not just served.
    ptr_d = ptr_q;
    if (gnt0) ptr_d = 1'b1;
    else if (gnt1) ptr_d = 1'b0;
  end

  always_ff @(posedge clk_f) begin
    if (reset) ptr_q <= 1'b0;
    else       ptr_q <= ptr_d;
  end
`else
  assign gnt0 = grant_ok && req0;
  assign gnt1 = grant_ok && req1 && !req0;
`endif

  assign rty_inc = (rty_q == RTY_MAX) ? rty_q : rty_q + 1'b1;

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    lock_d  = lock_q;
    rty_d   = rty_q;
    case (state_q)
      ST_INIT: begin
        if (cyc_q >= INIT_LAST) begin
          state_d = ST_TRAIN;
          cyc_d   = '0;
          lock_d  = '0;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      ST_TRAIN: begin
        // Lock is tested first so it wins over a coincident timeout.
        if (rx_active && (lock_q >= LOCK_LAST)) begin
          state_d = ST_LINK;
          cyc_d   = '0;
          lock_d  = '0;
          rty_d   = '0;
        end else if (cyc_q >= TRAIN_LAST) begin
          state_d = (rty_inc == RTY_MAX) ? ST_FAIL : ST_INIT;
          rty_d   = rty_inc;
          cyc_d   = '0;
          lock_d  = '0;
        end else begin
          cyc_d  = (cyc_q == CYC_SAT) ? cyc_q : cyc_q + 1'b1;
          lock_d = rx_active ? lock_q + 1'b1 : '0;
        end
      end
      ST_LINK: begin
        if (!rx_active) begin
          state_d = ST_TRAIN;
          cyc_d   = '0;
          lock_d  = '0;
        end
      end
      default: begin
        state_d = ST_FAIL;
      end
    endcase

    valid_d     = gnt0 || gnt1;
    data_d      = gnt0 ? data0 : (gnt1 ? data1 : data_q);
    active_d    = (state_d == ST_TRAIN) || (state_d == ST_LINK);
    link_fail_d = (state_d == ST_FAIL);
  end

  always_ff @(posedge clk_f) begin
    if (reset) begin
      state_q     <= ST_INIT;
      cyc_q       <= '0;
      lock_q      <= '0;
      rty_q       <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      active_q    <= 1'b0;
      link_fail_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      lock_q      <= lock_d;
      rty_q       <= rty_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      active_q    <= active_d;
      link_fail_q <= link_fail_d;
    end
  end

  assign state      = state_q;
  assign data_input = data_q;
  assign valid      = valid_q;
  assign active     = active_q;
  assign link_fail  = link_fail_q;

endmodule

// File: tb/tb_phy_tx_sched.sv
// Directed self-checking bench for phy_tx_sched (default parameters).
// Inputs change and outputs are checked on the falling clock edge.
module tb_phy_tx_sched;

  logic        clk_f;
  logic        reset;
  logic        req0;
  logic [31:0] data0;
  logic        req1;
  logic [31:0] data1;
  logic        rx_active;
  logic        gnt0;
  logic        gnt1;
  logic [31:0] data_input;
  logic        valid;
  logic        active;
  logic [1:0]  state;
  logic        link_fail;

  int n_total = 0;
  int n_bad   = 0;

  phy_tx_sched dut (
    .clk_f      (clk_f),
    .reset      (reset),
    .req0       (req0),
    .data0      (data0),
    .req1       (req1),
    .data1      (data1),
    .rx_active  (rx_active),
    .gnt0       (gnt0),
    .gnt1       (gnt1),
    .data_input (data_input),
    .valid      (valid),
    .active     (active),
    .state      (state),
    .link_fail  (link_fail)
  );

  initial clk_f = 1'b0;
  always #5 clk_f = ~clk_f;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk_f);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic exp_g0;
    reset = 1'b1; rx_active = 1'b1;
    req0 = 1'b1; req1 = 1'b0; data0 = 32'h0; data1 = 32'h0;
    step(); step(); #1;
    // reset state, and no grant while reset is high
    check_eq("rst_gnt0", gnt0, 0);
    check_eq("rst_state", state, 0);
    check_eq("rst_active", active, 0);
    check_eq("rst_valid", valid, 0);
    check_eq("rst_data", data_input, 0);
    check_eq("rst_link_fail", link_fail, 0);
    $display("txn reset: state=%0d", state);

    // bring-up with rx_active held high
    req0 = 1'b0; reset = 1'b0; #1;
    for (int i = 0; i < 4; i++) begin
      check_eq("init_state", state, 0);
      check_eq("init_active", active, 0);
      step(); #1;
    end
    check_eq("train_state", state, 1);
    check_eq("train_active", active, 1);
    check_eq("train_valid", valid, 0);
    step(); #1;
    check_eq("train2_state", state, 1);
    step(); #1;
    check_eq("link_state", state, 2);
    check_eq("link_valid", valid, 0);
    $display("txn bring-up: state=%0d active=%0d", state, active);

    // single word from requester 0
    req0 = 1'b1; data0 = 32'hAAAA_0001; #1;
    check_eq("w0_gnt0", gnt0, 1);
    check_eq("w0_gnt1", gnt1, 0);
    step(); req0 = 1'b0; #1;
    check_eq("w0_valid", valid, 1);
    check_eq("w0_data", data_input, 32'hAAAA_0001);
    check_eq("w0_gnt0_off", gnt0, 0);
    step(); #1;
    check_eq("idle_valid", valid, 0);
    check_eq("idle_hold", data_input, 32'hAAAA_0001);
    $display("txn word0: data=%h", 32'hAAAA_0001);

    // single word from requester 1 (also returns a round-robin pointer to 0)
    req1 = 1'b1; data1 = 32'h5555_0002; #1;
    check_eq("w1_gnt1", gnt1, 1);
    check_eq("w1_gnt0", gnt0, 0);
    step(); req1 = 1'b0; #1;
    check_eq("w1_valid", valid, 1);
    check_eq("w1_data", data_input, 32'h5555_0002);
    $display("txn word1: data=%h", 32'h5555_0002);

    // both requesting for 4 cycles
    req0 = 1'b1; req1 = 1'b1; data0 = 32'h1111_0000; data1 = 32'h2222_0000;
    for (int i = 0; i < 4; i++) begin
      #1;
`ifdef PHY_SCHED_RR_EN
      exp_g0 = (i % 2 == 0);
`else
      exp_g0 = 1'b1;
`endif
      check_eq("tie_gnt0", gnt0, exp_g0);
      check_eq("tie_gnt1", gnt1, !exp_g0);
      step(); #1;
      check_eq("tie_valid", valid, 1);
      check_eq("tie_data", data_input, exp_g0 ? 32'h1111_0000 : 32'h2222_0000);
      $display("txn tie %0d: gnt0=%0d", i, exp_g0);
    end
    req0 = 1'b0; req1 = 1'b0;

    // rx_active drops for one cycle while req0 is high
    req0 = 1'b1; data0 = 32'hCAFE_0003; rx_active = 1'b0; #1;
    check_eq("drop_gnt0", gnt0, 0);
    check_eq("drop_gnt1", gnt1, 0);
    step(); rx_active = 1'b1; #1;
    check_eq("drop_state", state, 1);
    check_eq("drop_valid", valid, 0);
    check_eq("drop_train_gnt0", gnt0, 0);
    step(); #1;
    check_eq("relock1_state", state, 1);
    step(); #1;
    check_eq("relock_state", state, 2);
    check_eq("relock_gnt0", gnt0, 1);
    step(); req0 = 1'b0; #1;
    check_eq("relock_valid", valid, 1);
    check_eq("relock_data", data_input, 32'hCAFE_0003);
    $display("txn relock: data=%h", 32'hCAFE_0003);

    // reset arriving in a grant cycle
    req0 = 1'b1; data0 = 32'hBEEF_0004; #1;
    check_eq("pre_rst_gnt0", gnt0, 1);
    reset = 1'b1; #1;
    check_eq("inrst_gnt0", gnt0, 0);
    check_eq("inrst_gnt1", gnt1, 0);
    step(); #1;
    check_eq("postrst_valid", valid, 0);
    check_eq("postrst_data", data_input, 0);
    check_eq("postrst_state", state, 0);
    check_eq("postrst_active", active, 0);
    $display("txn reset-in-grant: state=%0d", state);

    // training never locks: three attempts then FAIL
    req0 = 1'b0; rx_active = 1'b0; reset = 1'b0; #1;
    for (int a = 0; a < 3; a++) begin
      for (int i = 0; i < 4; i++) begin
        check_eq("to_init_state", state, 0);
        check_eq("to_init_active", active, 0);
        step(); #1;
      end
      for (int i = 0; i < 64; i++) begin
        check_eq("to_train_state", state, 1);
        check_eq("to_train_active", active, 1);
        step(); #1;
      end
      $display("txn train attempt %0d timed out", a);
    end
    check_eq("fail_state", state, 3);
    check_eq("fail_link_fail", link_fail, 1);
    check_eq("fail_active", active, 0);
    rx_active = 1'b1;
    repeat (5) step();
    #1;
    check_eq("fail_hold_state", state, 3);
    check_eq("fail_hold_link_fail", link_fail, 1);
    check_eq("fail_hold_valid", valid, 0);
    $display("txn fail latched: state=%0d", state);

    // lock on the last allowed training cycle wins over the timeout
    reset = 1'b1; step(); reset = 1'b0; rx_active = 1'b0; #1;
    check_eq("rel_link_fail", link_fail, 0);
    for (int i = 0; i < 4; i++) begin
      check_eq("edge_init_state", state, 0);
      step(); #1;
    end
    for (int t = 0; t < 64; t++) begin
      rx_active = (t >= 62); #1;
      check_eq("edge_train_state", state, 1);
      step(); #1;
    end
    check_eq("edge_lock_state", state, 2);
    check_eq("edge_lock_link_fail", link_fail, 0);
    $display("txn lock-at-timeout: state=%0d", state);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
